// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel-rate enable
// Counters, syncs and begin pulses are all registered on the same edge so they stay skew-free.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       clk_25mhz,
  output logic       pix_en,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       vga_active,
  output logic       h_begin,
  output logic       v_begin,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]       HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]       VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             clk_div_q, clk_div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             active_q, active_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             h_begin_q, h_begin_d;
  logic             v_begin_q, v_begin_d;
  logic [7:0]       frame_q, frame_d;
  logic             h_wrap;

  assign pix_en = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    clk_div_d = (div_cnt_d >= DIV_HALF);

    h_wrap = pix_en && (h_q == H_LAST);
    h_d    = h_q;
    v_d    = v_q;
    if (pix_en) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end
    end

    // Decode from next-state counters so the registered flags line up with pixel_x/pixel_y.
    active_d  = (h_d < H_VIS) && (v_d < V_VIS);
    hsync_d   = ((h_d >= HS_BEG) && (h_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d   = ((v_d >= VS_BEG) && (v_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    h_begin_d = pix_en && (h_d == 10'd0);
    v_begin_d = h_begin_d && (v_d == 10'd0);
    frame_d   = frame_q + {7'd0, v_begin_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      clk_div_q <= 1'b0;
      h_q       <= H_LAST;
      v_q       <= V_LAST;
      active_q  <= 1'b0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      h_begin_q <= 1'b0;
      v_begin_q <= 1'b0;
      frame_q   <= 8'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_div_q <= clk_div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      active_q  <= active_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      h_begin_q <= h_begin_d;
      v_begin_q <= v_begin_d;
      frame_q   <= frame_d;
    end
  end

  assign clk_25mhz  = clk_div_q;
  assign pixel_x    = h_q;
  assign pixel_y    = v_q;
  assign vga_active = active_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign h_begin    = h_begin_q;
  assign v_begin    = v_begin_q;
  assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of VGA timing at full and reduced raster sizes
// dut_a: default 640x480 timing; dut_b: 10x6 raster, CLK_DIV=4, active-high syncs.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a_n, rst_b_n;
  always #5 clk = ~clk;

  logic       a_clk, a_pe, a_act, a_hb, a_vb, a_hs, a_vs;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;
  logic       b_clk, b_pe, b_act, b_hb, b_vb, b_hs, b_vs;
  logic [9:0] b_x, b_y;
  logic [7:0] b_fc;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_a_n), .clk_25mhz(a_clk), .pix_en(a_pe),
    .pixel_x(a_x), .pixel_y(a_y), .vga_active(a_act), .h_begin(a_hb),
    .v_begin(a_vb), .hsync(a_hs), .vsync(a_vs), .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .clk_25mhz(b_clk), .pix_en(b_pe),
    .pixel_x(b_x), .pixel_y(b_y), .vga_active(b_act), .h_begin(b_hb),
    .v_begin(b_vb), .hsync(b_hs), .vsync(b_vs), .frame_cnt(b_fc)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst_a(input string p);
    check({p, ".x"}, 32'(a_x), 799);
    check({p, ".y"}, 32'(a_y), 524);
    check({p, ".act"}, 32'(a_act), 0);
    check({p, ".hb"}, 32'(a_hb), 0);
    check({p, ".vb"}, 32'(a_vb), 0);
    check({p, ".pe"}, 32'(a_pe), 0);
    check({p, ".hs"}, 32'(a_hs), 1);
    check({p, ".vs"}, 32'(a_vs), 1);
    check({p, ".clk"}, 32'(a_clk), 0);
    check({p, ".fc"}, 32'(a_fc), 0);
  endtask

  task automatic check_rst_b(input string p);
    check({p, ".x"}, 32'(b_x), 9);
    check({p, ".y"}, 32'(b_y), 5);
    check({p, ".hs"}, 32'(b_hs), 0);
    check({p, ".vs"}, 32'(b_vs), 0);
    check({p, ".hb"}, 32'(b_hb), 0);
    check({p, ".vb"}, 32'(b_vb), 0);
    check({p, ".fc"}, 32'(b_fc), 0);
  endtask

  int x_err, y_err, act_err, pe_err, hs_low, hs_first, hb_cnt, hb_at, vb_cnt, exp_x;
  int act640, found;
  int p, ex, ey, efc, bx_err, by_err, bact_err, bhs_err, bvs_err, bhb_err, bvb_err;
  int bpe_err, bclk_err, bfc_err, act_hi, hs_hi, vs_hi, clk_hi, hs_fx, vs_fx, vs_fy;
  int vb_n, vb_prev, vb_first, per_err, fc256;
  logic eph, ehb, evb, epe, eclk, eact, ehs, evs;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) tick();
    check_rst_a("a.rst");
    check_rst_b("b.rst");

    @(negedge clk);
    rst_a_n = 1'b1;
    tick();
    check("a.e1.x", 32'(a_x), 799);
    check("a.e1.vb", 32'(a_vb), 0);
    check("a.e1.pe", 32'(a_pe), 1);
    check("a.e1.clk", 32'(a_clk), 1);
    tick();
    check("a.e2.x", 32'(a_x), 0);
    check("a.e2.y", 32'(a_y), 0);
    check("a.e2.vb", 32'(a_vb), 1);
    check("a.e2.hb", 32'(a_hb), 1);
    check("a.e2.act", 32'(a_act), 1);
    check("a.e2.fc", 32'(a_fc), 1);
    check("a.e2.pe", 32'(a_pe), 0);
    check("a.e2.clk", 32'(a_clk), 0);
    tick();
    check("a.e3.vb", 32'(a_vb), 0);
    check("a.e3.hb", 32'(a_hb), 0);
    check("a.e3.x", 32'(a_x), 0);

    x_err = 0; y_err = 0; act_err = 0; pe_err = 0; hs_low = 0; hs_first = -1;
    hb_cnt = 0; hb_at = -1; vb_cnt = 0; act640 = -1;
    for (int t = 2; t <= 1600; t++) begin
      tick();
      exp_x = (t / 2) % 800;
      if (int'(a_x) != exp_x) x_err++;
      if (int'(a_y) != ((t >= 1600) ? 1 : 0)) y_err++;
      if (a_act !== (exp_x < 640)) act_err++;
      if (a_pe !== ((t % 2) == 1)) pe_err++;
      if (exp_x == 640 && act640 < 0) act640 = int'(a_act);
      if (a_hs == 1'b0) begin
        if (hs_low == 0) hs_first = int'(a_x);
        hs_low++;
      end
      if (a_hb) begin hb_cnt++; hb_at = t; end
      if (a_vb) vb_cnt++;
    end
    check("a.line.x", 32'(x_err), 0);
    check("a.line.y", 32'(y_err), 0);
    check("a.line.act", 32'(act_err), 0);
    check("a.line.pe", 32'(pe_err), 0);
    check("a.act_at_640", 32'(act640), 0);
    check("a.hs_low_clks", 32'(hs_low), 192);
    check("a.hs_first_x", 32'(hs_first), 656);
    check("a.hb_count", 32'(hb_cnt), 1);
    check("a.hb_period", 32'(hb_at), 1600);
    check("a.vb_in_line", 32'(vb_cnt), 0);

    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick();
      if (a_x == 10'd300 && a_y == 10'd1) found = 1;
    end
    check("a.seek", 32'(found), 1);
    #3 rst_a_n = 1'b0;
    #1 check_rst_a("a.arst");
    repeat (3) tick();
    check_rst_a("a.hold");
    @(negedge clk);
    rst_a_n = 1'b1;
    tick();
    check("a.re1.x", 32'(a_x), 799);
    tick();
    check("a.re2.x", 32'(a_x), 0);
    check("a.re2.y", 32'(a_y), 0);
    check("a.re2.vb", 32'(a_vb), 1);
    check("a.re2.fc", 32'(a_fc), 1);

    bx_err = 0; by_err = 0; bact_err = 0; bhs_err = 0; bvs_err = 0; bhb_err = 0;
    bvb_err = 0; bpe_err = 0; bclk_err = 0; bfc_err = 0; act_hi = 0; hs_hi = 0;
    vs_hi = 0; clk_hi = 0; hs_fx = -1; vs_fx = -1; vs_fy = -1; vb_n = 0;
    vb_prev = 0; vb_first = -1; per_err = 0; fc256 = -1;
    @(negedge clk);
    rst_b_n = 1'b1;
    for (int t = 1; t <= 61210; t++) begin
      tick();
      if (t < 4) begin
        ex = 9; ey = 5; efc = 0;
      end else begin
        p = (t - 4) / 4;
        ex = p % 10;
        ey = (p / 10) % 6;
        efc = ((t - 4) / 240 + 1) % 256;
      end
      eph  = (t >= 4) && ((t - 4) % 4 == 0);
      ehb  = eph && (ex == 0);
      evb  = ehb && (ey == 0);
      epe  = (t % 4) == 3;
      eclk = (t % 4) >= 2;
      eact = (ex < 4) && (ey < 3);
      ehs  = (ex >= 5) && (ex <= 6);
      evs  = (ey == 4);
      if (int'(b_x) != ex) bx_err++;
      if (int'(b_y) != ey) by_err++;
      if (int'(b_fc) != efc) bfc_err++;
      if (b_act !== eact) bact_err++;
      if (b_hs !== ehs) bhs_err++;
      if (b_vs !== evs) bvs_err++;
      if (b_hb !== ehb) bhb_err++;
      if (b_vb !== evb) bvb_err++;
      if (b_pe !== epe) bpe_err++;
      if (b_clk !== eclk) bclk_err++;
      if (t >= 4 && t < 244) begin
        if (b_act) act_hi++;
        if (b_clk) clk_hi++;
        if (b_hs) begin
          if (hs_hi == 0) hs_fx = int'(b_x);
          hs_hi++;
        end
        if (b_vs) begin
          if (vs_hi == 0) begin vs_fx = int'(b_x); vs_fy = int'(b_y); end
          vs_hi++;
        end
      end
      if (b_vb) begin
        vb_n++;
        if (vb_n == 1) vb_first = t;
        if (vb_n > 1 && (t - vb_prev) != 240) per_err++;
        if (vb_n == 256) fc256 = int'(b_fc);
        vb_prev = t;
      end
    end
    check("b.model.x", 32'(bx_err), 0);
    check("b.model.y", 32'(by_err), 0);
    check("b.model.fc", 32'(bfc_err), 0);
    check("b.model.act", 32'(bact_err), 0);
    check("b.model.hs", 32'(bhs_err), 0);
    check("b.model.vs", 32'(bvs_err), 0);
    check("b.model.hb", 32'(bhb_err), 0);
    check("b.model.vb", 32'(bvb_err), 0);
    check("b.model.pe", 32'(bpe_err), 0);
    check("b.model.clk", 32'(bclk_err), 0);
    check("b.act_clks", 32'(act_hi), 48);
    check("b.hs_clks", 32'(hs_hi), 48);
    check("b.hs_first_x", 32'(hs_fx), 5);
    check("b.vs_clks", 32'(vs_hi), 40);
    check("b.vs_first_x", 32'(vs_fx), 0);
    check("b.vs_first_y", 32'(vs_fy), 4);
    check("b.clk_hi", 32'(clk_hi), 120);
    check("b.vb_first", 32'(vb_first), 4);
    check("b.vb_count", 32'(vb_n), 256);
    check("b.vb_period", 32'(per_err), 0);
    check("b.fc_wrap", 32'(fc256), 0);

    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      tick();
      if (b_x == 10'd5 && b_y == 10'd2) found = 1;
    end
    check("b.seek", 32'(found), 1);
    #3 rst_b_n = 1'b0;
    #1 check_rst_b("b.arst");
    repeat (3) tick();
    check_rst_b("b.hold");
    @(negedge clk);
    rst_b_n = 1'b1;
    repeat (3) tick();
    check("b.re3.x", 32'(b_x), 9);
    check("b.re3.pe", 32'(b_pe), 1);
    tick();
    check("b.re4.x", 32'(b_x), 0);
    check("b.re4.y", 32'(b_y), 0);
    check("b.re4.vb", 32'(b_vb), 1);
    check("b.re4.fc", 32'(b_fc), 1);
    check("b.re4.act", 32'(b_act), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
